// File: rtl/game_pkg.sv
// game_pkg: shared types, direction codes and controller states for the 2048 move controller.
package game_pkg;
  typedef logic [11:0] tile_t;
  typedef tile_t [3:0][3:0] board_t;
  typedef logic [19:0] score_t;
  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;
  localparam tile_t WIN_VALUE_DEFAULT = 12'd2048;
  typedef enum logic [2:0] {INIT_SPAWN, WAIT_DIR, MOVE, COMMIT, SPAWN, CHECK, WON, OVER} state_t;
endpackage

// File: rtl/game_move_controller_if.sv
// game_move_controller_if: link between the controller and the move/merge datapath.
interface game_move_controller_if;
  import game_pkg::*;
  logic [3:0] mm_direction;
  board_t mm_board_in;
  board_t mm_board_out;
  score_t mm_score_update;
  logic mm_done;
  modport master(output mm_direction, mm_board_in, input mm_board_out, mm_score_update, mm_done);
  modport slave(input mm_direction, mm_board_in, output mm_board_out, mm_score_update, mm_done);
endinterface

// File: rtl/tile_spawner.sv
// tile_spawner: free-running LFSR plus a one-cell-per-cycle search for an empty cell.
module tile_spawner import game_pkg::*; #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  board_t     board,
  output logic       done,
  output logic       found,
  output logic [1:0] row,
  output logic [1:0] col,
  output tile_t      value
);
  logic [15:0] lfsr;
  logic active, empty;
  logic [3:0] idx, cnt, cur, cnt_cur;
  tile_t val_q;
  // the first cycle of a request tests the LFSR-chosen cell directly, so a full scan is 16 cycles
  always_comb begin
    cur = active ? idx : lfsr[3:0];
    cnt_cur = active ? cnt : 4'd0;
    value = active ? val_q : (lfsr[7:4] == 4'd0 ? 12'd4 : 12'd2);
    empty = board[cur[3:2]][cur[1:0]] == '0;
    found = start && empty;
    done = start && (empty || cnt_cur == 4'd15);
  end
  assign row = cur[3:2];
  assign col = cur[1:0];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lfsr <= LFSR_SEED;
      active <= 1'b0;
      idx <= '0;
      cnt <= '0;
      val_q <= '0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      active <= start && !done;
      idx <= cur + 4'd1;
      cnt <= cnt_cur + 4'd1;
      val_q <= value;
    end
endmodule

// File: rtl/game_move_controller.sv
// game_move_controller: 2048 game sequencer driving an external move/merge datapath.
module game_move_controller import game_pkg::*; #(
  parameter tile_t       WIN_VALUE = WIN_VALUE_DEFAULT,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] dir_req,
  input  logic       restart,
  game_move_controller_if.master mm,
  output board_t     board,
  output score_t     score,
  output logic       busy,
  output logic       game_won,
  output logic       game_over
);
  state_t state, state_n;
  logic [3:0] dir_q;
  board_t cap_board;
  score_t cap_score;
  logic init_cnt, win, lose, sp_start, sp_done, sp_found;
  logic [1:0] sp_row, sp_col;
  tile_t sp_value;
  logic [20:0] sum;
  tile_spawner #(.LFSR_SEED(LFSR_SEED)) u_spawner (
    .clk(clk), .rst(rst), .start(sp_start), .board(board),
    .done(sp_done), .found(sp_found), .row(sp_row), .col(sp_col), .value(sp_value)
  );
  always_comb begin
    win = 1'b0;
    lose = 1'b1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        win |= board[r][c] == WIN_VALUE;
        lose &= board[r][c] != '0;
      end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++) lose &= board[r][c] != board[r][c+1];
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) lose &= board[r][c] != board[r+1][c];
  end
  always_comb begin
    state_n = state;
    case (state)
      INIT_SPAWN: if (sp_done && init_cnt) state_n = CHECK;
      WAIT_DIR:   if ($onehot(dir_req)) state_n = MOVE;
      MOVE:       if (mm.mm_done) state_n = COMMIT;
      COMMIT:     state_n = cap_board == board ? WAIT_DIR : SPAWN;
      SPAWN:      if (sp_done) state_n = CHECK;
      CHECK:      state_n = win ? WON : lose ? OVER : WAIT_DIR;
      default:    state_n = state;
    endcase
    if (restart) state_n = INIT_SPAWN;
  end
  assign sp_start = (state == INIT_SPAWN || state == SPAWN) && !restart;
  assign busy = !(state inside {WAIT_DIR, WON, OVER});
  assign game_won = state == WON;
  assign game_over = state == OVER;
  assign mm.mm_direction = state == MOVE ? dir_q : 4'd0;
  assign mm.mm_board_in = board;
  assign sum = {1'b0, score} + {1'b0, cap_score};
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= INIT_SPAWN;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      board <= '0;
      score <= '0;
      cap_board <= '0;
      cap_score <= '0;
      dir_q <= '0;
      init_cnt <= 1'b0;
    end else if (restart) begin
      board <= '0;
      score <= '0;
      init_cnt <= 1'b0;
    end else begin
      if (state == WAIT_DIR) dir_q <= dir_req;
      if (state == MOVE && mm.mm_done) begin
        cap_board <= mm.mm_board_out;
        cap_score <= mm.mm_score_update;
      end
      if (state == COMMIT && state_n == SPAWN) begin
        board <= cap_board;
        score <= sum[20] ? '1 : sum[19:0];
      end
      if (sp_start && sp_found) board[sp_row][sp_col] <= sp_value;
      if (state == INIT_SPAWN && sp_done) init_cnt <= !init_cnt;
    end
endmodule

// File: tb/tb_game_move_controller.sv
// tb_game_move_controller: directed and random moves against a rule-level game model.
module tb_game_move_controller;
  import game_pkg::*;
  localparam logic [15:0] SEED = 16'hACE1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic restart = 1'b0;
  logic [3:0] dir_req = 4'd0;
  board_t board;
  score_t score;
  logic busy, game_won, game_over;
  logic [15:0] m_lfsr;
  board_t board_m;
  score_t score_m;
  int checks = 0;
  int errors = 0;
  game_move_controller_if mif();
  game_move_controller #(.WIN_VALUE(12'd2048), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .dir_req(dir_req), .restart(restart), .mm(mif.master),
    .board(board), .score(score), .busy(busy), .game_won(game_won), .game_over(game_over)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] lfsr_step(logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction
  always @(posedge clk or posedge rst) m_lfsr <= rst ? SEED : lfsr_step(m_lfsr);
  function automatic board_t spawn_model(board_t b, logic [15:0] l);
    int s = int'(l[3:0]);
    for (int k = 0; k < 16; k++) begin
      int i = (s + k) % 16;
      if (b[i/4][i%4] == 12'd0) begin
        b[i/4][i%4] = (l[7:4] == 4'd0) ? 12'd4 : 12'd2;
        return b;
      end
    end
    return b;
  endfunction
  function automatic logic [1:0] flags(board_t b);
    logic w = 1'b0;
    logic stuck = 1'b1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        if (b[r][c] == 12'd2048) w = 1'b1;
        if (b[r][c] == 12'd0) stuck = 1'b0;
        if (c < 3 && b[r][c] == b[r][c+1]) stuck = 1'b0;
        if (r < 3 && b[r][c] == b[r+1][c]) stuck = 1'b0;
      end
    return {w, stuck && !w};
  endfunction
  function automatic board_t rand_board();
    board_t b;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[r][c] = ($urandom_range(0, 2) == 0) ? 12'd0 : 12'(12'd2 << $urandom_range(0, 4));
    return b;
  endfunction
  function automatic board_t checker_board();
    board_t b;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) b[r][c] = ((r + c) % 2 == 1) ? 12'd4 : 12'd2;
    return b;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_idle;
    for (int i = 0; i < 40 && busy; i++) tick;
    check("idle_within_budget", busy, 1'b0);
  endtask
  task automatic check_game(input string tag);
    logic [1:0] f = flags(board_m);
    check({tag, "_board"}, board, board_m);
    check({tag, "_score"}, score, score_m);
    check({tag, "_won"}, game_won, f[1]);
    check({tag, "_over"}, game_over, f[0]);
  endtask
  task automatic expect_new_game(input string tag);
    logic [15:0] l0, l1;
    l0 = m_lfsr;
    tick;
    mif.mm_done = 1'b0;
    l1 = m_lfsr;
    board_m = spawn_model(spawn_model('0, l0), l1);
    score_m = '0;
    wait_idle;
    check_game(tag);
  endtask
  task automatic restart_game(input string tag);
    restart = 1'b1;
    tick;
    restart = 1'b0;
    expect_new_game(tag);
  endtask
  task automatic do_move(input string tag, input logic [3:0] d, input board_t res, input score_t upd, input int dly);
    bit changed = res != board_m;
    dir_req = d;
    tick;
    dir_req = 4'd0;
    check({tag, "_dir"}, mif.mm_direction, d);
    check({tag, "_board_in"}, mif.mm_board_in, board_m);
    repeat (dly - 1) tick;
    mif.mm_board_out = res;
    mif.mm_score_update = upd;
    mif.mm_done = 1'b1;
    tick;
    mif.mm_done = 1'b0;
    dir_req = DIR_RIGHT;
    tick;
    dir_req = 4'd0;
    if (changed) begin
      board_m = spawn_model(res, m_lfsr);
      score_m = (int'(score_m) + int'(upd) > 'hFFFFF) ? 20'hFFFFF : score_m + upd;
      wait_idle;
    end else check({tag, "_nochange_idle"}, busy, 1'b0);
    check_game(tag);
    tick;
    check({tag, "_not_queued"}, mif.mm_direction, 4'd0);
  endtask
  initial begin
    board_t b;
    logic [1:0] f;
    mif.mm_board_out = '0;
    mif.mm_score_update = '0;
    mif.mm_done = 1'b0;
    tick;
    tick;
    check("rst_board", board, '0);
    check("rst_score", score, '0);
    check("rst_busy", busy, 1'b1);
    check("rst_dir", mif.mm_direction, 4'd0);
    check("rst_flags", {game_won, game_over}, 2'b00);
    rst = 1'b0;
    expect_new_game("init");
    dir_req = 4'b0101;
    tick;
    dir_req = 4'd0;
    check("multibit_ignored", {busy, mif.mm_direction}, 5'd0);
    b = board_m;
    b[0][0] = 12'd2; b[0][1] = 12'd2; b[0][2] = 12'd4; b[0][3] = 12'd0;
    do_move("setup", DIR_DOWN, b, 20'd0, 2);
    b = board_m;
    b[0][0] = 12'd4; b[0][1] = 12'd4; b[0][2] = 12'd0; b[0][3] = 12'd0;
    do_move("merge_left", DIR_LEFT, b, 20'd4, 3);
    do_move("identical", DIR_UP, board_m, 20'd8, 2);
    for (int n = 0; n < 10; n++) begin
      b = ($urandom_range(0, 3) == 0) ? board_m : rand_board();
      do_move("random", 4'(4'd1 << $urandom_range(0, 3)), b,
              ($urandom_range(0, 3) == 0) ? 20'hFFFF0 : 20'($urandom_range(0, 512)), $urandom_range(1, 4));
      f = flags(board_m);
      if (f != 2'b00) restart_game("random_restart");
    end
    restart_game("pre_sat");
    b = board_m; b[3][3] = 12'd8; b[3][2] = 12'd16;
    do_move("sat1", DIR_UP, b, 20'hFFFF0, 1);
    b = board_m; b[2][3] = 12'd32;
    do_move("sat2", DIR_DOWN, b, 20'h00100, 1);
    restart_game("pre_over");
    do_move("over", DIR_DOWN, checker_board(), 20'd16, 2);
    dir_req = DIR_LEFT;
    tick;
    tick;
    dir_req = 4'd0;
    check("over_dir_ignored", {game_over, mif.mm_direction}, 5'b1_0000);
    restart_game("after_over");
    b = checker_board();
    b[0][0] = 12'd2048;
    do_move("won", DIR_RIGHT, b, 20'd2048, 1);
    restart_game("after_won");
    dir_req = DIR_LEFT;
    tick;
    dir_req = 4'd0;
    tick;
    restart = 1'b1;
    tick;
    restart = 1'b0;
    mif.mm_board_out = {16{12'd2048}};
    mif.mm_score_update = 20'hFFFFF;
    mif.mm_done = 1'b1;
    expect_new_game("restart_mid_move");
    dir_req = DIR_UP;
    tick;
    dir_req = 4'd0;
    #2 rst = 1'b1;
    tick;
    check("rst_mid_move_dir", mif.mm_direction, 4'd0);
    rst = 1'b0;
    mif.mm_done = 1'b1;
    expect_new_game("rst_mid_move");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end
endmodule
